// File: rtl/cellram_req_sequencer_pkg.sv
// Shared types and constants for the CellRAM request sequencer: command entry layout,
// FSM encoding and the data returned on a timed-out read.
package cellram_req_sequencer_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;

    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } seq_state_e;

    // Queue entry; packs to CMD_W bits with write in the MSB and wdata in the LSBs.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cr_cmd_t;

endpackage

// File: rtl/cellram_req_sequencer_if.sv
// Client request/response port plus the controller-facing strobe/DQ signals.
interface cellram_req_sequencer_if;
    import cellram_req_sequencer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              cr__read;
    logic              cr__write;
    logic [ADDR_W-1:0] cr__addr;
    logic [DATA_W-1:0] cr__data_in;
    logic              async_cr__wait;
    logic [DATA_W-1:0] dq_in;
    logic              timeout_err;
    logic              idle;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, async_cr__wait, dq_in,
        output req_ready, rsp_valid, rsp_rdata, cr__read, cr__write, cr__addr, cr__data_in,
               timeout_err, idle
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, async_cr__wait, dq_in,
        input  req_ready, rsp_valid, rsp_rdata, cr__read, cr__write, cr__addr, cr__data_in,
               timeout_err, idle
    );

endinterface

// File: rtl/cellram_req_sequencer_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty; pointers carry an extra wrap bit.
module cellram_req_sequencer_cmd_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign wr_ptr_nxt = wr_ptr + PTR_W'(do_push);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
    assign head       = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[PTR_W-1] != rd_ptr_nxt[PTR_W-1]) &&
                      (wr_ptr_nxt[IDX_W-1:0] == rd_ptr_nxt[IDX_W-1:0]);
        end
    end

    // Storage needs no reset; empty gates every use of head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cellram_req_sequencer.sv
// Queues client read/write requests and issues them one at a time to the async CellRAM
// controller, tracking its wait flag and returning read data on the response port.
module cellram_req_sequencer
    import cellram_req_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_b,
    cellram_req_sequencer_if.slave   bus
);

    localparam int unsigned TMR_W = $clog2(WAIT_TIMEOUT);

    seq_state_e        state;
    seq_state_e        state_nxt;
    cr_cmd_t           push_cmd;
    cr_cmd_t           head_cmd;
    logic [CMD_W-1:0]  head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              issue_go;
    logic              busy_done;
    logic              timed_out;
    logic [TMR_W-1:0]  timer;
    logic              op_is_read;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              timeout_err_q;
    logic              cr_read_q;
    logic              cr_write_q;
    logic [ADDR_W-1:0] cr_addr_q;
    logic [DATA_W-1:0] cr_data_q;

    assign push_cmd = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
    assign head_cmd = cr_cmd_t'(head_bits);

    cellram_req_sequencer_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (bus.req_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; reads are held off while an unconsumed response is pending.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        busy_done = 1'b0;
        timed_out = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty && !bus.async_cr__wait && (head_cmd.write || !rsp_valid_q)) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_BUSY;
                fifo_pop  = 1'b1;
            end
            ST_BUSY: begin
                if (!bus.async_cr__wait) begin
                    state_nxt = ST_IDLE;
                    busy_done = 1'b1;
                end else if (timer == TMR_W'(WAIT_TIMEOUT - 1)) begin
                    state_nxt = ST_IDLE;
                    timed_out = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign issue_go = (state_nxt == ST_ISSUE);

    // Strobes and address/data are registered so they are high exactly in the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cr_read_q     <= 1'b0;
            cr_write_q    <= 1'b0;
            cr_addr_q     <= '0;
            cr_data_q     <= '0;
            op_is_read    <= 1'b0;
            timer         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cr_read_q  <= issue_go && !head_cmd.write;
            cr_write_q <= issue_go && head_cmd.write;
            if (issue_go) begin
                cr_addr_q  <= head_cmd.addr;
                cr_data_q  <= head_cmd.wdata;
                op_is_read <= !head_cmd.write;
            end

            if (state == ST_ISSUE) begin
                timer <= '0;
            end else if (state == ST_BUSY) begin
                timer <= timer + TMR_W'(1);
            end

            if (busy_done && op_is_read) begin
                rsp_rdata_q <= bus.dq_in;
                rsp_valid_q <= 1'b1;
            end else if (timed_out && op_is_read) begin
                rsp_rdata_q <= TIMEOUT_RDATA;
                rsp_valid_q <= 1'b1;
            end else if (rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            if (timed_out) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = !fifo_full;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.cr__read    = cr_read_q;
    assign bus.cr__write   = cr_write_q;
    assign bus.cr__addr    = cr_addr_q;
    assign bus.cr__data_in = cr_data_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.idle        = (state == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_cellram_req_sequencer.sv
// Directed bench for cellram_req_sequencer with a small wait/DQ model of the controller.
module tb_cellram_req_sequencer;
    import cellram_req_sequencer_pkg::*;

    logic clk;
    logic rst_b;
    cellram_req_sequencer_if bus ();

    int          wait_len;
    logic        force_wait;
    int          wcnt;
    logic [15:0] dq_val;
    cr_cmd_t     slog [$];
    logic        both_seen;
    int          n_checks;
    int          n_errors;

    cellram_req_sequencer #(
        .FIFO_DEPTH   (4),
        .WAIT_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: wait covers the strobe cycle plus wait_len following cycles.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) wcnt <= 0;
        else if (bus.cr__read || bus.cr__write) wcnt <= wait_len;
        else if (wcnt != 0) wcnt <= wcnt - 1;
    end
    assign bus.async_cr__wait = bus.cr__read | bus.cr__write | (wcnt != 0) | force_wait;
    assign bus.dq_in          = bus.async_cr__wait ? 16'hDEAD : dq_val;

    // One log entry per strobe cycle.
    always @(negedge clk) begin
        if (bus.cr__read && bus.cr__write) both_seen <= 1'b1;
        if (bus.cr__read || bus.cr__write)
            slog.push_back('{write: bus.cr__write, addr: bus.cr__addr, wdata: bus.cr__data_in});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [23:0] a, input logic [15:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Count ticks until rsp_valid, bounded.
    task automatic wait_rsp(input string tag, input int exp_ticks);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(exp_ticks));
    endtask

    task automatic consume_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!bus.idle && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.idle), 64'(1));
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        chk({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        chk({pfx, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
        chk({pfx, "_cr_read"}, 64'(bus.cr__read), 64'(0));
        chk({pfx, "_cr_write"}, 64'(bus.cr__write), 64'(0));
        chk({pfx, "_timeout_err"}, 64'(bus.timeout_err), 64'(0));
        chk({pfx, "_idle"}, 64'(bus.idle), 64'(1));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        both_seen     = 1'b0;
        rst_b         = 1'b0;
        wait_len      = 0;
        force_wait    = 1'b0;
        dq_val        = 16'h0000;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) tick();
        chk_reset_vals("rst0");
        rst_b = 1'b1;
        repeat (2) tick();

        // Write: strobe exactly in cycle N+2.
        slog.delete();
        push(1'b1, 24'h000010, 16'hA5A5);
        chk("wr_n1_strobe", 64'(bus.cr__write), 64'(0));
        chk("wr_n1_idle", 64'(bus.idle), 64'(0));
        tick();
        chk("wr_n2_strobe", 64'(bus.cr__write), 64'(1));
        chk("wr_n2_read", 64'(bus.cr__read), 64'(0));
        chk("wr_n2_addr", 64'(bus.cr__addr), 64'h10);
        chk("wr_n2_data", 64'(bus.cr__data_in), 64'hA5A5);
        tick();
        chk("wr_n3_strobe", 64'(bus.cr__write), 64'(0));
        chk("wr_n3_addr_hold", 64'(bus.cr__addr), 64'h10);
        repeat (3) tick();
        chk("wr_no_rsp", 64'(bus.rsp_valid), 64'(0));
        chk("wr_one_strobe", 64'(slog.size()), 64'(1));

        // Read with 6 wait cycles.
        wait_len = 6;
        dq_val   = 16'h1234;
        push(1'b0, 24'h000020, 16'h0000);
        tick();
        chk("rd_strobe", 64'(bus.cr__read), 64'(1));
        chk("rd_addr", 64'(bus.cr__addr), 64'h20);
        wait_rsp("rd_latency", 8);
        chk("rd_rdata", 64'(bus.rsp_rdata), 64'h1234);
        repeat (3) tick();
        chk("rd_rsp_held", 64'(bus.rsp_valid), 64'(1));
        consume_rsp();
        chk("rd_rsp_cleared", 64'(bus.rsp_valid), 64'(0));

        // Queue fill while controller busy.
        wait_len   = 0;
        force_wait = 1'b1;
        slog.delete();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_ready%0d", i), 64'(bus.req_ready), 64'(1));
            push(1'b1, 24'h000100 + 24'(i), 16'(16'h1111 * (i + 1)));
        end
        chk("fill_full", 64'(bus.req_ready), 64'(0));
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 24'h000104;
        bus.req_wdata = 16'h5555;
        repeat (3) tick();
        chk("fill_still_full", 64'(bus.req_ready), 64'(0));
        chk("fill_no_issue", 64'(slog.size()), 64'(0));
        force_wait = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.req_ready && n < 50) begin
                tick();
                n++;
            end
            chk("fill_ready_again", 64'(bus.req_ready), 64'(1));
        end
        tick();
        bus.req_valid = 1'b0;
        wait_idle("fill_drain_idle");
        chk("fill_count", 64'(slog.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < slog.size()) begin
                chk($sformatf("fill_order_addr%0d", i), 64'(slog[i].addr), 64'h100 + 64'(i));
                chk($sformatf("fill_order_data%0d", i), 64'(slog[i].wdata), 64'(16'h1111 * (i + 1)));
            end
        end

        // Second read stalls behind an unconsumed response.
        slog.delete();
        dq_val = 16'hBEEF;
        push(1'b0, 24'h000200, 16'h0000);
        push(1'b0, 24'h000204, 16'h0000);
        repeat (10) tick();
        chk("stall_one_issue", 64'(slog.size()), 64'(1));
        chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("stall_rdata", 64'(bus.rsp_rdata), 64'hBEEF);
        chk("stall_not_idle", 64'(bus.idle), 64'(0));
        dq_val = 16'hCAFE;
        consume_rsp();
        chk("stall_m1_strobe", 64'(bus.cr__read), 64'(0));
        tick();
        chk("stall_m2_strobe", 64'(bus.cr__read), 64'(1));
        chk("stall_m2_addr", 64'(bus.cr__addr), 64'h204);
        wait_rsp("stall_second_latency", 2);
        chk("stall_second_rdata", 64'(bus.rsp_rdata), 64'hCAFE);
        consume_rsp();

        // Longest wait that still completes normally.
        wait_len = 63;
        dq_val   = 16'h7E57;
        push(1'b0, 24'h000300, 16'h0000);
        tick();
        wait_rsp("edge63_latency", 65);
        chk("edge63_rdata", 64'(bus.rsp_rdata), 64'h7E57);
        chk("edge63_no_timeout", 64'(bus.timeout_err), 64'(0));
        consume_rsp();

        // One more wait cycle times out.
        wait_len = 64;
        push(1'b0, 24'h000310, 16'h0000);
        tick();
        wait_rsp("tmo_latency", 65);
        chk("tmo_err", 64'(bus.timeout_err), 64'(1));
        chk("tmo_rdata", 64'(bus.rsp_rdata), 64'hFFFF);
        chk("tmo_idle", 64'(bus.idle), 64'(1));
        consume_rsp();
        wait_len = 0;
        tick();
        push(1'b1, 24'h000400, 16'h5A5A);
        tick();
        chk("tmo_next_strobe", 64'(bus.cr__write), 64'(1));
        chk("tmo_next_addr", 64'(bus.cr__addr), 64'h400);
        repeat (3) tick();
        chk("tmo_err_sticky", 64'(bus.timeout_err), 64'(1));

        // Reset in the middle of a read with another op queued.
        wait_len = 20;
        push(1'b0, 24'h000500, 16'h0000);
        push(1'b1, 24'h000504, 16'h1357);
        repeat (4) tick();
        chk("mid_not_idle", 64'(bus.idle), 64'(0));
        rst_b = 1'b0;
        tick();
        chk_reset_vals("mid");
        rst_b = 1'b1;
        slog.delete();
        repeat (6) tick();
        chk("mid_queue_discarded", 64'(slog.size()), 64'(0));
        chk("mid_idle_after", 64'(bus.idle), 64'(1));

        chk("never_both_strobes", 64'(both_seen), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
